// File: rtl/zb_tx_pkg.sv
// zb_tx_pkg
// Shared definitions for the 802.15.4 transmit byte-to-symbol path.
//   SYM_W  : symbol width in bits
//   DATA_W : payload word width in bits
//   SYMS   : symbols per word
//   IDX_W  : width of a symbol index within a word (never below 1 bit)
//   tx_state_t : serializer FSM states
package zb_tx_pkg;

    localparam int SYM_W  = 4;
    localparam int DATA_W = 8;
    localparam int SYMS   = DATA_W / SYM_W;
    localparam int IDX_W  = (SYMS > 1) ? $clog2(SYMS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/nibble_mux.sv
// nibble_mux
// Combinational SYMS:1 selector of SYM_W-bit slices of a word. Slice 0 is
// the least-significant one. An index past the last slice yields zero.
// Ports:
//   word : SYMS*SYM_W-bit source word
//   sel  : slice index
//   sym  : selected slice
module nibble_mux #(
    parameter int SYM_W = 4,
    parameter int SYMS  = 2,
    parameter int SEL_W = 1
) (
    input  logic [SYMS*SYM_W-1:0] word,
    input  logic [SEL_W-1:0]      sel,
    output logic [SYM_W-1:0]      sym
);

    logic [SYMS-1:0][SYM_W-1:0] slices;

    assign slices = word;

    // Compare-and-select keeps non-power-of-two SYMS safe from
    // out-of-range indexing.
    always_comb begin
        sym = '0;
        for (int i = 0; i < SYMS; i++) begin
            if (sel == SEL_W'(i)) sym = slices[i];
        end
    end

endmodule

// File: rtl/byte_to_symbol_mux.sv
// byte_to_symbol_mux
// Serializes payload bytes into SYM_W-bit symbols, LSB symbol first, for the
// chip-spreading stage. The frame-end flag rides with the byte and is shown
// on its final symbol only. When the final symbol transfers, a waiting byte is
// taken in the same cycle, so streaming has no gaps.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inData    : byte to serialize
//   inValid   : inData/inLast valid
//   inLast    : byte closes the frame
//   outReady  : byte accepted this cycle when inValid is high
//   outSym    : current symbol (zero while idle)
//   outValid  : outSym/outIdx/outLast valid
//   inReady   : downstream takes the symbol this cycle
//   outIdx    : symbol position within its byte (0 = LSB symbol)
//   outLast   : current symbol ends the frame
module byte_to_symbol_mux
    import zb_tx_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int SYM_W    = 4,
    localparam int NUM_SYMS = DATA_W / SYM_W,
    localparam int SEL_W    = (NUM_SYMS > 1) ? $clog2(NUM_SYMS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    input  logic              inLast,
    output logic              outReady,
    output logic [SYM_W-1:0]  outSym,
    output logic              outValid,
    input  logic              inReady,
    output logic [SEL_W-1:0]  outIdx,
    output logic              outLast
);

    tx_state_t         state, stateNext;
    logic [DATA_W-1:0] hold, holdNext;
    logic [SEL_W-1:0]  idx, idxNext;
    logic              lastReg, lastNext;

    logic              lastSym;
    logic              symXfer;
    logic              byteXfer;
    logic [SYM_W-1:0]  muxSym;

    assign lastSym  = (idx == SEL_W'(NUM_SYMS - 1));
    assign outValid = (state == SEND);
    assign symXfer  = outValid && inReady;
    // The only input-to-output combinational path: a byte may enter as the
    // final symbol of the current one leaves.
    assign outReady = (state == IDLE) || (lastSym && symXfer);
    assign byteXfer = inValid && outReady;

    nibble_mux #(
        .SYM_W (SYM_W),
        .SYMS  (NUM_SYMS),
        .SEL_W (SEL_W)
    ) uMux (
        .word (hold),
        .sel  (idx),
        .sym  (muxSym)
    );

    assign outSym  = outValid ? muxSym : '0;
    assign outIdx  = idx;
    assign outLast = outValid && lastReg && lastSym;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            idx     <= '0;
            lastReg <= 1'b0;
        end else begin
            state   <= stateNext;
            hold    <= holdNext;
            idx     <= idxNext;
            lastReg <= lastNext;
        end
    end

    always_comb begin
        stateNext = state;
        holdNext  = hold;
        idxNext   = idx;
        lastNext  = lastReg;
        unique case (state)
            IDLE: begin
                if (byteXfer) begin
                    holdNext  = inData;
                    lastNext  = inLast;
                    idxNext   = '0;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (symXfer) begin
                    if (!lastSym) begin
                        idxNext = idx + SEL_W'(1);
                    end else if (byteXfer) begin
                        holdNext = inData;
                        lastNext = inLast;
                        idxNext  = '0;
                    end else begin
                        // Park idx at 0 so outIdx reads 0 while idle.
                        idxNext   = '0;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/byte_to_symbol_mux.md
# byte_to_symbol_mux

Sequential byte-to-symbol serializer for the Zigbee (IEEE 802.15.4) transmit path. It accepts one payload byte at a time over a valid/ready handshake and emits it as consecutive 4-bit symbols, least-significant nibble first, to the chip-spreading stage. It is the transmit-side counterpart of the receive-side nibble demultiplexers, which reassemble symbols into bytes. It carries a frame-end marker from the last byte through to that byte's last symbol.

## Interface
Parameters:
- DATA_W, 8, input word width in bits; must be an integer multiple of SYM_W.
- SYM_W, 4, output symbol width in bits.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- inData  in  DATA_W  byte to serialize.
- inValid  in  1  inData and inLast are valid this cycle.
- inLast  in  1  this byte is the final byte of the frame.
- outReady  out  1  block can accept a byte this cycle.
- outSym  out  SYM_W  current symbol.
- outValid  out  1  outSym, outIdx and outLast are valid.
- inReady  in  1  downstream stage accepts the symbol this cycle.
- outIdx  out  log2(DATA_W/SYM_W)  index of the current symbol within its byte (0 = LSB nibble).
- outLast  out  1  current symbol is the last symbol of the frame.

## Operation
- SYMS = DATA_W/SYM_W (2 at defaults).
- Byte transfer happens when inValid && outReady.
- Symbol transfer happens when outValid && inReady.
- State machine:
  - IDLE: outValid=0, outReady=1. A byte transfer latches inData into the hold register and inLast into lastReg, sets idx=0, and moves to SEND.
  - SEND: outValid=1. outSym = hold[idx*SYM_W +: SYM_W]. outIdx = idx. outLast = lastReg && (idx==SYMS-1).
    - Symbol transfer with idx<SYMS-1: idx increments.
    - Symbol transfer with idx==SYMS-1: if a byte transfers in the same cycle, load the new byte, set idx=0, and stay in SEND (gapless streaming). Otherwise go to IDLE.
- outReady = (state==IDLE) || (state==SEND && idx==SYMS-1 && inReady). outReady depends combinationally on inReady. There is no other combinational path from inputs to outputs.
- Stall: while outValid && !inReady, outSym, outIdx and outLast hold stable. inData is ignored.
- inValid is ignored while outReady=0; the upstream stage must hold its byte.
- The frame marker has no effect on sequencing. A frame of one byte simply ends with outLast on symbol SYMS-1.
- Reset, including mid-byte: state=IDLE, hold=0, idx=0, lastReg=0. Any partially sent byte is discarded.

## Timing
Reset values of outputs:
- outValid=0, outSym=0, outIdx=0, outLast=0.
- outReady=1 (combinational, from IDLE).

Latency and throughput:
- Latency: a byte accepted on edge N gives symbol 0 on outValid from after edge N through edge N+1.
- Throughput: with inReady held high and inValid held high, one symbol per cycle with no bubbles. This is SYMS cycles per byte.
- Idle gap: when no byte is available at the last symbol, outValid drops the cycle after that symbol transfers.

Boundary conditions:
- inReady low during the last symbol: outReady is low, and the next byte waits.
- inReady toggling every cycle: each symbol is held until it transfers. No symbol is duplicated or skipped.

## Structure
- Package zb_tx_pkg holds:
  - localparams SYM_W=4, DATA_W=8, SYMS, IDX_W.
  - state enum tx_state_t {IDLE, SEND}.
- Sub-module nibble_mux: a combinational SYMS:1 selector of SYM_W-bit slices by index. It is the inverse of the receive-side demux and is reused by the chip-spreader lookup.
- The top level holds the FSM, the hold register, the idx counter, lastReg, and the handshake logic.

## Test plan
1. Reset → outValid=0, outReady=1, outSym=0.
2. Single byte 0xA5, inLast=1, inReady=1 → outSym 5 (idx 0, outLast=0), then A (idx 1, outLast=1), then outValid=0.
3. Bytes 0x12, 0x34, 0x56 streamed back-to-back, inReady=1, inLast on 0x56 → symbols 2,1,4,3,6,5 on consecutive cycles with no gap. outLast only on the final 5.
4. Byte 0x3C with inReady low for 3 cycles on idx 0 → outSym=C held stable for 3 cycles. outReady=0 throughout the stall. After release: C, then 3.
5. Byte 0x9F, then assert rst after symbol F transfers → all outputs return to reset values immediately. A new byte 0x01 then yields 1, 0.
6. inValid=1 with outReady=0 (mid-byte) → the offered byte is not consumed. It is accepted only in the cycle the last symbol transfers.
